rsa_modexp_ctrl: RTL

RSA_MODEXP_CTRL -- requirements
Module: rsa_modexp_ctrl

---
 rtl/rsa_pkg.sv | 20 ++
 rtl/rsa_req_hs.sv | 38 +++
 rtl/rsa_modexp_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular-exponentiation controller:
// default operand width, FSM state encoding and the constant one.
package rsa_pkg;

  localparam int W_DEFAULT = 128;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    SQ_MUL = 3'd2,
    SQ_DIV = 3'd3,
    MU_MUL = 3'd4,
    MU_DIV = 3'd5,
    NEXT   = 3'd6,
    FINISH = 3'd7
  } state_t;

  localparam logic [W_DEFAULT-1:0] ONE = W_DEFAULT'(1);

endpackage

// File: rtl/rsa_req_hs.sv
// Request side of a req/ack handshake: holds req from launch until ack,
// latches the response data on ack and flags that cycle with fire_o.
module rsa_req_hs #(
  parameter int DW = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          launch_i,
  input  logic          ack_i,
  input  logic [DW-1:0] data_i,
  output logic          req_o,
  output logic [DW-1:0] data_o,
  output logic          fire_o
);

  // Handshake: req rises on the edge after launch_i, stays high until ack_i
  // is sampled with req high, and falls on that same edge. An ack seen while
  // req is low is ignored. fire_o is high exactly in the accepted-ack cycle.
  logic          req_q;
  logic [DW-1:0] data_q;

  assign fire_o = req_q & ack_i;
  assign req_o  = req_q;
  assign data_o = data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q  <= 1'b0;
      data_q <= '0;
    end else if (fire_o) begin
      req_q  <= 1'b0;
      data_q <= data_i;
    end else if (launch_i) begin
      req_q  <= 1'b1;
    end
  end

endmodule

// File: rtl/rsa_modexp_ctrl.sv
// Left-to-right square-and-multiply controller for base^exp mod modulus,
// driving external multiplier and divider units over req/ack handshakes.
module rsa_modexp_ctrl
  import rsa_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   base,
  input  logic [W-1:0]   exp,
  input  logic [W-1:0]   modulus,
  output logic           busy,
  output logic           done,
  output logic           error,
  output logic [W-1:0]   result,
  output logic           mul_req,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic           mul_ack,
  input  logic [2*W-1:0] mul_p,
  output logic           div_req,
  output logic [2*W-1:0] div_num,
  output logic [W-1:0]   div_den,
  input  logic           div_ack,
  input  logic [W-1:0]   div_rem
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;

  state_t         state_q;
  logic [W-1:0]   base_q, exp_q, mod_q;
  logic [W-1:0]   mul_a_q, mul_b_q, result_q;
  logic [IW-1:0]  idx_q;
  logic           busy_q, done_q, error_q;
  logic           mul_launch, div_launch, mul_fire, div_fire, cur_bit;
  logic [2*W-1:0] prod_q;
  logic [W-1:0]   acc;

  // The divider handshake's latched remainder is the accumulator itself.
  rsa_req_hs #(.DW(2*W)) u_mul_hs (
    .clk      (clk),
    .reset    (reset),
    .launch_i (mul_launch),
    .ack_i    (mul_ack),
    .data_i   (mul_p),
    .req_o    (mul_req),
    .data_o   (prod_q),
    .fire_o   (mul_fire)
  );

  rsa_req_hs #(.DW(W)) u_div_hs (
    .clk      (clk),
    .reset    (reset),
    .launch_i (div_launch),
    .ack_i    (div_ack),
    .data_i   (div_rem),
    .req_o    (div_req),
    .data_o   (acc),
    .fire_o   (div_fire)
  );

  assign cur_bit = exp_q[idx_q];
  assign busy    = busy_q;
  assign done    = done_q;
  assign error   = error_q;
  assign result  = result_q;
  assign mul_a   = mul_a_q;
  assign mul_b   = mul_b_q;
  assign div_num = prod_q;
  assign div_den = mod_q;

  // Launches coincide with the state transition so req is high on state entry.
  always_comb begin
    mul_launch = 1'b0;
    div_launch = 1'b0;
    case (state_q)
      CHECK:          mul_launch = (mod_q != '0);
      SQ_DIV:         mul_launch = div_fire & cur_bit;
      NEXT:           mul_launch = (idx_q != '0);
      SQ_MUL, MU_MUL: div_launch = mul_fire;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      base_q   <= '0;
      exp_q    <= '0;
      mod_q    <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      result_q <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            base_q  <= base;
            exp_q   <= exp;
            mod_q   <= modulus;
            idx_q   <= IW'(W - 1);
            busy_q  <= 1'b1;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (mod_q == '0) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            error_q  <= 1'b1;
            result_q <= '0;
            state_q  <= FINISH;
          end else begin
            mul_a_q <= W'(ONE);
            mul_b_q <= W'(ONE);
            state_q <= SQ_MUL;
          end
        end
        SQ_MUL: if (mul_fire) state_q <= SQ_DIV;
        SQ_DIV: begin
          if (div_fire) begin
            if (cur_bit) begin
              // Fresh remainder is only visible on div_rem in this cycle.
              mul_a_q <= div_rem;
              mul_b_q <= base_q;
              state_q <= MU_MUL;
            end else begin
              state_q <= NEXT;
            end
          end
        end
        MU_MUL: if (mul_fire) state_q <= MU_DIV;
        MU_DIV: if (div_fire) state_q <= NEXT;
        NEXT: begin
          if (idx_q == '0) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            error_q  <= 1'b0;
            result_q <= acc;
            state_q  <= FINISH;
          end else begin
            idx_q   <= idx_q - IW'(1);
            mul_a_q <= acc;
            mul_b_q <= acc;
            state_q <= SQ_MUL;
          end
        end
        FINISH:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
